map_data_structure_pipelined: RTL and testbench

Parametrised, handshaked key/value map with registered responses. Each accepted request (insert, delete or lookup) produces exactly one response carrying a status code, value and slot index. Slots are managed by an internal free-list FIFO, and occupancy is exported. It is the successor to the combinational-response map and sits between a request producer and a consumer that may stall.

---
 rtl/map_data_structure_pipelined_if.sv | 31 +++
 rtl/map_data_structure_pipelined.sv | 209 ++++++++++++++++++++
 tb/tb_map_data_structure_pipelined.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/map_data_structure_pipelined_if.sv
// Request/response bundle for map_data_structure_pipelined: a producer-side
// request channel and a consumer-side response channel, both valid/ready.
interface map_data_structure_pipelined_if #(
  parameter int KEY_WIDTH   = 8,
  parameter int VALUE_WIDTH = 16,
  parameter int MAP_SIZE    = 16
);
  localparam int IDX_W = $clog2(MAP_SIZE);

  logic                   req_valid;
  logic                   req_ready;
  logic [1:0]             req_op;
  logic [KEY_WIDTH-1:0]   req_key;
  logic [VALUE_WIDTH-1:0] req_value;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [2:0]             rsp_status;
  logic [VALUE_WIDTH-1:0] rsp_value;
  logic [IDX_W-1:0]       rsp_index;

  modport master (
    output req_valid, req_op, req_key, req_value, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_value, rsp_index
  );

  modport slave (
    input  req_valid, req_op, req_key, req_value, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_value, rsp_index
  );
endinterface

// File: rtl/map_data_structure_pipelined.sv
// Key/value map with a FIFO free list of slots and a one-entry registered
// response stage. Define MAP_FLUSH_EN to add the flush port.
module map_data_structure_pipelined #(
  parameter  int KEY_WIDTH   = 8,
  parameter  int VALUE_WIDTH = 16,
  parameter  int MAP_SIZE    = 16,
  localparam int IDX_W       = $clog2(MAP_SIZE)
) (
  input  logic                           clk,
  input  logic                           reset,
`ifdef MAP_FLUSH_EN
  input  logic                           flush,
`endif
  map_data_structure_pipelined_if.slave  bus,
  output logic [IDX_W:0]                 occupancy,
  output logic                           full,
  output logic                           empty
);

  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_LOOKUP = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_NOP      = 3'd0,
    ST_HIT      = 3'd1,
    ST_MISS     = 3'd2,
    ST_INSERTED = 3'd3,
    ST_UPDATED  = 3'd4,
    ST_DELETED  = 3'd5,
    ST_FULL     = 3'd6
  } status_e;

  logic [KEY_WIDTH-1:0]   keys_q   [MAP_SIZE];
  logic [VALUE_WIDTH-1:0] values_q [MAP_SIZE];
  logic [IDX_W-1:0]       free_q   [MAP_SIZE];
  logic [MAP_SIZE-1:0]    valid_q, valid_d;
  logic [IDX_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]         occ_q, occ_d;

  logic                   rsp_valid_q, rsp_valid_d;
  status_e                rsp_status_q, rsp_status_d;
  logic [VALUE_WIDTH-1:0] rsp_value_q, rsp_value_d;
  logic [IDX_W-1:0]       rsp_index_q, rsp_index_d;

  logic                   accept;
  op_e                    op;
  logic                   hit;
  logic [IDX_W-1:0]       hit_idx;
  logic [IDX_W-1:0]       alloc_idx;
  logic                   store_en;
  logic                   store_key_en;
  logic [IDX_W-1:0]       store_idx;
  logic                   free_push;

`ifdef MAP_FLUSH_EN
  assign bus.req_ready = (!rsp_valid_q || bus.rsp_ready) && !flush;
`else
  assign bus.req_ready = !rsp_valid_q || bus.rsp_ready;
`endif

  assign accept    = bus.req_valid && bus.req_ready;
  assign op        = op_e'(bus.req_op);
  assign alloc_idx = free_q[rd_ptr_q];

  assign occupancy = occ_q;
  assign full      = (occ_q == (IDX_W+1)'(MAP_SIZE));
  assign empty     = (occ_q == '0);

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_value  = rsp_value_q;
  assign bus.rsp_index  = rsp_index_q;

  // Scan from the top down so the lowest matching slot is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = MAP_SIZE - 1; i >= 0; i--) begin
      if (valid_q[i] && keys_q[i] == bus.req_key) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // NOTE: every output of this block is defaulted first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    valid_d      = valid_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    occ_d        = occ_q;
    store_en     = 1'b0;
    store_key_en = 1'b0;
    store_idx    = hit_idx;
    free_push    = 1'b0;
    rsp_valid_d  = rsp_valid_q && !bus.rsp_ready;
    rsp_status_d = rsp_status_q;
    rsp_value_d  = rsp_value_q;
    rsp_index_d  = rsp_index_q;

    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_status_d = ST_NOP;
      rsp_value_d  = '0;
      rsp_index_d  = '0;
      case (op)
        OP_LOOKUP: begin
          if (hit) begin
            rsp_status_d = ST_HIT;
            rsp_value_d  = values_q[hit_idx];
            rsp_index_d  = hit_idx;
          end else begin
            rsp_status_d = ST_MISS;
          end
        end
        OP_INSERT: begin
          if (hit) begin
            store_en     = 1'b1;
            rsp_status_d = ST_UPDATED;
            rsp_value_d  = values_q[hit_idx];
            rsp_index_d  = hit_idx;
          end else if (full) begin
            rsp_status_d = ST_FULL;
          end else begin
            store_en           = 1'b1;
            store_key_en       = 1'b1;
            store_idx          = alloc_idx;
            valid_d[alloc_idx] = 1'b1;
            rd_ptr_d           = rd_ptr_q + IDX_W'(1);
            occ_d              = occ_q + (IDX_W+1)'(1);
            rsp_status_d       = ST_INSERTED;
            rsp_index_d        = alloc_idx;
          end
        end
        OP_DELETE: begin
          if (hit) begin
            valid_d[hit_idx] = 1'b0;
            free_push        = 1'b1;
            wr_ptr_d         = wr_ptr_q + IDX_W'(1);
            occ_d            = occ_q - (IDX_W+1)'(1);
            rsp_status_d     = ST_DELETED;
            rsp_value_d      = values_q[hit_idx];
            rsp_index_d      = hit_idx;
          end else begin
            rsp_status_d = ST_MISS;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < MAP_SIZE; i++) free_q[i] <= IDX_W'(i);
`ifdef MAP_FLUSH_EN
    end else if (flush) begin
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < MAP_SIZE; i++) free_q[i] <= IDX_W'(i);
`endif
    end else begin
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      if (free_push) free_q[wr_ptr_q] <= hit_idx;
    end
  end

  // NOTE: key/value storage is deliberately not reset; valid_q guards every
  // read, so leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (store_en) begin
      values_q[store_idx] <= bus.req_value;
      if (store_key_en) keys_q[store_idx] <= bus.req_key;
    end
  end

  // Response stage holds its payload until the consumer takes it; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= ST_NOP;
      rsp_value_q  <= '0;
      rsp_index_q  <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_value_q  <= rsp_value_d;
      rsp_index_q  <= rsp_index_d;
    end
  end

endmodule

// File: tb/tb_map_data_structure_pipelined.sv
// Scoreboard bench for map_data_structure_pipelined: a queue/associative-array
// model predicts each response; a monitor pops and compares on every handshake.
module tb_map_data_structure_pipelined;
  localparam int KW = 8;
  localparam int VW = 16;
  localparam int MS = 16;
  localparam int IW = 4;

  localparam int OP_NOP = 0, OP_INS = 1, OP_DEL = 2, OP_LKP = 3;
  localparam logic [2:0] S_NOP = 3'd0, S_HIT = 3'd1, S_MISS = 3'd2, S_INS = 3'd3,
                         S_UPD = 3'd4, S_DEL = 3'd5, S_FULL = 3'd6;

  logic          clk = 1'b0;
  logic          reset;
`ifdef MAP_FLUSH_EN
  logic          flush;
`endif
  logic [IW:0]   occupancy;
  logic          full;
  logic          empty;

  always #5 clk = ~clk;

  map_data_structure_pipelined_if #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .MAP_SIZE(MS)) bus ();

  map_data_structure_pipelined #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .MAP_SIZE(MS)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef MAP_FLUSH_EN
    .flush     (flush),
`endif
    .bus       (bus),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );

  typedef struct packed {
    logic [2:0]    st;
    logic [VW-1:0] val;
    logic [IW-1:0] idx;
  } rsp_t;

  rsp_t          exp_q [$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            rdy_mode = 0;  // 0 always ready, 1 random, 2 stalled

  // Reference model: key -> value/slot, plus the queue of free slots.
  logic [VW-1:0] m_val [int];
  int            m_idx [int];
  int            free_l [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_val.delete();
    m_idx.delete();
    free_l.delete();
    for (int i = 0; i < MS; i++) free_l.push_back(i);
  endfunction

  function automatic rsp_t model_apply(input int op, input int key, input logic [VW-1:0] val);
    rsp_t r;
    r = '0;
    case (op)
      OP_LKP: begin
        if (m_val.exists(key)) r = '{S_HIT, m_val[key], IW'(m_idx[key])};
        else                   r.st = S_MISS;
      end
      OP_INS: begin
        if (m_val.exists(key)) begin
          r = '{S_UPD, m_val[key], IW'(m_idx[key])};
          m_val[key] = val;
        end else if (free_l.size() == 0) begin
          r.st = S_FULL;
        end else begin
          int slot;
          slot       = free_l.pop_front();
          m_val[key] = val;
          m_idx[key] = slot;
          r = '{S_INS, '0, IW'(slot)};
        end
      end
      OP_DEL: begin
        if (m_val.exists(key)) begin
          r = '{S_DEL, m_val[key], IW'(m_idx[key])};
          free_l.push_back(m_idx[key]);
          m_val.delete(key);
          m_idx.delete(key);
        end else begin
          r.st = S_MISS;
        end
      end
      default: r.st = S_NOP;
    endcase
    return r;
  endfunction

  // Monitor: compare on every response handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rsp: got status %0d expected none", bus.rsp_status);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          check("rsp_status", 32'(bus.rsp_status), 32'(e.st));
          check("rsp_value",  32'(bus.rsp_value),  32'(e.val));
          check("rsp_index",  32'(bus.rsp_index),  32'(e.idx));
        end
      end
    end
  end

  // Consumer: rsp_ready changes shortly after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = 1'($urandom_range(0, 1));
        default: bus.rsp_ready = 1'b0;
      endcase
    end
  end

  // Called 1 time unit after a rising edge; returns 1 unit after the accepting edge.
  task automatic send(input int op, input int key, input logic [VW-1:0] val, output int waits);
    bit done;
    waits         = 0;
    done          = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'(op);
    bus.req_key   = KW'(key);
    bus.req_value = val;
    while (!done) begin
      @(negedge clk);
      if (bus.req_ready) begin
        exp_q.push_back(model_apply(op, key, val));
        done = 1;
      end else if (waits > 200) begin
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
        done = 1;
      end else begin
        waits++;
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom);
    bus.req_key   = KW'($urandom);
    bus.req_value = VW'($urandom);
  endtask

  task automatic send_nw(input int op, input int key, input logic [VW-1:0] val);
    int w;
    send(op, key, val, w);
  endtask

  // Drain all responses, then check occupancy flags against the model.
  task automatic wait_idle(input string tag);
    bit idle;
    idle     = 0;
    rdy_mode = 0;
    for (int c = 0; c < 100 && !idle; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.rsp_valid) idle = 1;
    end
    check({tag, "_drained"}, 32'(idle), 32'd1);
    check({tag, "_occupancy"}, 32'(occupancy), 32'(m_val.num()));
    check({tag, "_full"},  32'(full),  32'(m_val.num() == MS));
    check({tag, "_empty"}, 32'(empty), 32'(m_val.num() == 0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]    h_st;
    logic [VW-1:0] h_val;
    logic [IW-1:0] h_idx;
    int            w;

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_key    = '0;
    bus.req_value  = '0;
    bus.rsp_ready  = 1'b1;
`ifdef MAP_FLUSH_EN
    flush          = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("reset_rsp_valid",  32'(bus.rsp_valid),  32'd0);
    check("reset_rsp_status", 32'(bus.rsp_status), 32'd0);
    check("reset_rsp_value",  32'(bus.rsp_value),  32'd0);
    check("reset_rsp_index",  32'(bus.rsp_index),  32'd0);
    check("reset_occupancy",  32'(occupancy),      32'd0);
    check("reset_empty",      32'(empty),          32'd1);
    check("reset_full",       32'(full),           32'd0);
    check("reset_req_ready",  32'(bus.req_ready),  32'd1);
    @(posedge clk);
    #1;

    // Empty map: delete of absent key, then NOP.
    send_nw(OP_DEL, 8'h55, 16'h0);
    send_nw(OP_NOP, 8'h55, 16'hAAAA);
    wait_idle("empty_map");

    // Insert, lookup, update, miss.
    send_nw(OP_INS, 8'h12, 16'hBEEF);
    send_nw(OP_LKP, 8'h12, 16'h0);
    wait_idle("first_insert");
    send_nw(OP_INS, 8'h12, 16'h1234);
    send_nw(OP_LKP, 8'h99, 16'h0);
    wait_idle("update");

    // Fill to capacity, overflow, delete slot 5, reuse it, update while full.
    for (int k = 8'h20; k <= 8'h2E; k++) send_nw(OP_INS, k, VW'(k * 3));
    wait_idle("filled");
    send_nw(OP_INS, 8'h77, 16'h7777);
    send_nw(OP_DEL, 8'h24, 16'h0);
    send_nw(OP_INS, 8'h78, 16'h7878);
    send_nw(OP_INS, 8'h12, 16'h5A5A);
    send_nw(OP_LKP, 8'h78, 16'h0);
    wait_idle("reuse_slot");

    // Consumer stall: one response held, request blocked, state frozen.
    rdy_mode = 2;
    send_nw(OP_LKP, 8'h78, 16'h0);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'(OP_DEL);
    bus.req_key   = 8'h12;
    bus.req_value = 16'h0;
    @(negedge clk);
    h_st  = bus.rsp_status;
    h_val = bus.rsp_value;
    h_idx = bus.rsp_index;
    for (int c = 0; c < 3; c++) begin
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
      check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_hold_status", 32'(bus.rsp_status), 32'(h_st));
      check("stall_hold_value",  32'(bus.rsp_value),  32'(h_val));
      check("stall_hold_index",  32'(bus.rsp_index),  32'(h_idx));
      check("stall_occupancy",   32'(occupancy),      32'(MS));
      if (c < 2) @(negedge clk);
    end
    @(posedge clk);
    #1;
    rdy_mode = 0;
    send_nw(OP_DEL, 8'h12, 16'h0);
    for (int k = 0; k < 4; k++) begin
      send(OP_LKP, 8'h20 + k, 16'h0, w);
      check("throughput_waits", 32'(w), 32'd0);
    end
    wait_idle("stall_release");

`ifdef MAP_FLUSH_EN
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    model_reset();
    for (int k = 0; k < 4; k++) send_nw(OP_INS, 8'h40 + k, VW'(16'h100 + k));
    wait_idle("pre_flush");
    rdy_mode = 2;
    send_nw(OP_LKP, 8'h41, 16'h0);
    flush = 1'b1;
    @(negedge clk);
    check("flush_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    model_reset();
    @(negedge clk);
    check("flush_occupancy", 32'(occupancy), 32'd0);
    check("flush_rsp_held",  32'(bus.rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    rdy_mode = 0;
    send_nw(OP_LKP, 8'h40, 16'h0);
    send_nw(OP_INS, 8'h50, 16'h5050);
    wait_idle("post_flush");
`endif

    // Randomized traffic with a random consumer.
    rdy_mode = 1;
    for (int n = 0; n < 400; n++) begin
      send_nw($urandom_range(0, 3), $urandom_range(0, 23), VW'($urandom));
    end
    wait_idle("random");

    // Reset while a response is pending.
    rdy_mode = 2;
    send_nw(OP_INS, 8'h33, 16'h3333);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    model_reset();
    reset = 1'b0;
    @(negedge clk);
    check("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midreset_occupancy", 32'(occupancy),     32'd0);
    @(posedge clk);
    #1;
    rdy_mode = 0;
    send_nw(OP_LKP, 8'h33, 16'h0);
    send_nw(OP_INS, 8'h34, 16'h3434);
    wait_idle("after_reset");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
